mem_arbiter: RTL

Two-port arbiter and sequencer in front of the single-read-port instruction/data memory. It shares the memory between the instruction-fetch unit (IF) and the load unit (LS) using valid/ready handshakes, and drives the memory's strobe and address. It returns the memory's one-cycle-latency read data to the requester that owns the transaction. Out-of-range addresses are rejected with an error response. At most one transaction is outstanding at a time.

---
 rtl/mem_arbiter_pkg.sv | 18 +
 rtl/mem_arbiter_if.sv | 44 ++++
 rtl/mem_arbiter_arb2.sv | 38 +++
 rtl/mem_arbiter.sv | 89 ++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and defaults for the two-port memory arbiter.
// Arbitration policy is chosen by the MEMARB_RR_EN macro (see mem_arbiter_arb2).
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_e;

  localparam int DEPTH_WORDS_DEF = 1024;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundles the IF/LS valid-ready channels and the memory strobe/address/data.
// The slave modport is the arbiter's view; master is the requester/memory side.
interface mem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          if_req_valid;
  logic          if_req_ready;
  logic [AW-1:0] if_req_addr;
  logic          if_resp_valid;
  logic          if_resp_ready;
  logic [DW-1:0] if_resp_data;
  logic          if_resp_err;

  logic          ls_req_valid;
  logic          ls_req_ready;
  logic [AW-1:0] ls_req_addr;
  logic          ls_resp_valid;
  logic          ls_resp_ready;
  logic [DW-1:0] ls_resp_data;
  logic          ls_resp_err;

  logic          mem_strb;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  if_req_valid, if_req_addr, if_resp_ready,
    input  ls_req_valid, ls_req_addr, ls_resp_ready,
    input  mem_rdata,
    output if_req_ready, if_resp_valid, if_resp_data, if_resp_err,
    output ls_req_ready, ls_resp_valid, ls_resp_data, ls_resp_err,
    output mem_strb, mem_addr
  );

  modport master (
    output if_req_valid, if_req_addr, if_resp_ready,
    output ls_req_valid, ls_req_addr, ls_resp_ready,
    output mem_rdata,
    input  if_req_ready, if_resp_valid, if_resp_data, if_resp_err,
    input  ls_req_ready, ls_resp_valid, ls_resp_data, ls_resp_err,
    input  mem_strb, mem_addr
  );
endinterface

// File: rtl/mem_arbiter_arb2.sv
// Two-way grant: bit 0 = IF, bit 1 = LS. With MEMARB_RR_EN defined a 1-bit
// last-grant pointer alternates on ties; otherwise LS has fixed priority.
module mem_arbiter_arb2
  import mem_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rstn,
  input  logic [1:0] req,
  input  logic       hs,
  output logic [1:0] gnt
);

`ifdef MEMARB_RR_EN
  owner_e ptr_q, ptr_d;

  // Reset value marks IF as last granted so that LS wins the first tie.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) ptr_q <= OWN_IF;
    else       ptr_q <= ptr_d;
  end

  always_comb begin
    gnt   = req;
    ptr_d = ptr_q;
    if (&req) gnt = (ptr_q == OWN_LS) ? 2'b01 : 2'b10;
    if (hs)   ptr_d = gnt[1] ? OWN_LS : OWN_IF;
  end
`else
  logic unused_rr;
  assign unused_rr = &{1'b0, clk, rstn, hs};

  always_comb begin
    gnt = req;
    if (&req) gnt = 2'b10;
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-read-port memory between IF and LS, one transaction at a time.
// Arbitration policy: round-robin when MEMARB_RR_EN is defined, LS-first otherwise.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int DEPTH_WORDS = DEPTH_WORDS_DEF
) (
  input  logic          clk,
  input  logic          rstn,
  mem_arbiter_if.slave  bus
);

  localparam logic [AW:0] LIMIT = (AW+1)'(64'(DEPTH_WORDS) * 64'd4);

  state_e        state_q, state_d;
  owner_e        own_q, own_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          err_q, err_d;

  logic [1:0]    gnt;
  logic          hs;
  logic          resp_rdy;
  logic [DW-1:0] resp_data;
  logic          if_own, ls_own;

  mem_arbiter_arb2 u_arb2 (
    .clk  (clk),
    .rstn (rstn),
    .req  ({bus.ls_req_valid, bus.if_req_valid}),
    .hs   (hs),
    .gnt  (gnt)
  );

  // Ready is gated by rstn so nothing is accepted while reset is held.
  assign hs = (state_q == IDLE) && rstn && (|gnt);

  assign bus.if_req_ready = hs & gnt[0];
  assign bus.ls_req_ready = hs & gnt[1];

  assign bus.mem_strb = (state_q == ISSUE);
  assign bus.mem_addr = bus.mem_strb ? addr_q : '0;

  assign if_own    = (state_q == RESP) && (own_q == OWN_IF);
  assign ls_own    = (state_q == RESP) && (own_q == OWN_LS);
  assign resp_data = err_q ? '0 : bus.mem_rdata;
  assign resp_rdy  = (own_q == OWN_LS) ? bus.ls_resp_ready : bus.if_resp_ready;

  assign bus.if_resp_valid = if_own;
  assign bus.if_resp_data  = if_own ? resp_data : '0;
  assign bus.if_resp_err   = if_own & err_q;
  assign bus.ls_resp_valid = ls_own;
  assign bus.ls_resp_data  = ls_own ? resp_data : '0;
  assign bus.ls_resp_err   = ls_own & err_q;

  always_comb begin
    state_d = state_q;
    own_d   = own_q;
    addr_d  = addr_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (hs) begin
          own_d   = gnt[1] ? OWN_LS : OWN_IF;
          addr_d  = gnt[1] ? bus.ls_req_addr : bus.if_req_addr;
          err_d   = ({1'b0, addr_d} >= LIMIT);
          state_d = err_d ? RESP : ISSUE;
        end
      end
      ISSUE:   state_d = RESP;
      RESP:    if (resp_rdy) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Transaction context is only observed in ISSUE/RESP, so it needs no reset.
  always_ff @(posedge clk) begin
    own_q  <= own_d;
    addr_q <= addr_d;
    err_q  <= err_d;
  end

endmodule
